// File: rtl/bidir_bus_port_ctrl_if.sv
// Request-side and pad-side signals of the half-duplex bus port controller.
// The slave modport is the controller; master is the requester plus pad ring.
interface bidir_bus_port_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             wr_req;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             busy;
   logic [WIDTH-1:0] pad_o;
   logic             pad_t;
   logic [WIDTH-1:0] pad_i;
   logic             pad_we_n;
   logic             pad_re_n;

   modport slave (
      input  wr_req, wr_data, rd_req, pad_i,
      output rd_data, rd_valid, busy, pad_o, pad_t, pad_we_n, pad_re_n
   );

   modport master (
      output wr_req, wr_data, rd_req, pad_i,
      input  rd_data, rd_valid, busy, pad_o, pad_t, pad_we_n, pad_re_n
   );
endinterface

// File: rtl/bidir_bus_port_ctrl.sv
// Half-duplex tri-state bus controller: write/read strobes with guaranteed
// released-bus turnaround between transfers. All outputs registered.
module bidir_bus_port_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned RD_WAIT     = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   bidir_bus_port_ctrl_if.slave     bus
);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WSETUP  = 3'd1,
      WSTROBE = 3'd2,
      WHOLD   = 3'd3,
      RSTROBE = 3'd4,
      TURN    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] pad_o_d, rd_data_d;
   logic             rd_valid_d, pad_t_d, we_n_d, re_n_d, busy_d;

   // Next state plus next registered outputs, decoded from the state being entered
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pad_o_d    = bus.pad_o;
      rd_data_d  = bus.rd_data;
      rd_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.wr_req) begin
               state_d = WSETUP;
               pad_o_d = bus.wr_data;
            end else if (bus.rd_req) begin
               state_d = RSTROBE;
               cnt_d   = CNT_W'(RD_WAIT - 1);
            end
         end
         WSETUP:  state_d = WSTROBE;
         WSTROBE: state_d = WHOLD;
         WHOLD: begin
            state_d = TURN;
            cnt_d   = CNT_W'(TURN_CYCLES - 1);
         end
         RSTROBE: begin
            if (cnt_q == '0) begin
               state_d    = TURN;
               cnt_d      = CNT_W'(TURN_CYCLES - 1);
               rd_data_d  = bus.pad_i;
               rd_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         TURN: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase

      // FPGA drives only in the three write states, so it can never overlap a read strobe
      pad_t_d = !(state_d == WSETUP || state_d == WSTROBE || state_d == WHOLD);
      we_n_d  = (state_d != WSTROBE);
      re_n_d  = (state_d != RSTROBE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bus.pad_o    <= '0;
         bus.pad_t    <= 1'b1;
         bus.pad_we_n <= 1'b1;
         bus.pad_re_n <= 1'b1;
         bus.busy     <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bus.pad_o    <= pad_o_d;
         bus.pad_t    <= pad_t_d;
         bus.pad_we_n <= we_n_d;
         bus.pad_re_n <= re_n_d;
         bus.busy     <= busy_d;
         bus.rd_valid <= rd_valid_d;
         bus.rd_data  <= rd_data_d;
      end
   end
endmodule

// File: tb/tb_bidir_bus_port_ctrl.sv
// Bench for bidir_bus_port_ctrl: directed scenarios then random requests,
// checked each cycle against a per-transaction timeline model.
module tb_bidir_bus_port_ctrl;
   localparam int unsigned WIDTH       = 8;
   localparam int unsigned TURN_CYCLES = 2;
   localparam int unsigned RD_WAIT     = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bidir_bus_port_ctrl_if #(.WIDTH(WIDTH)) bif ();

   // Device model: drives its value only while the read strobe is low
   logic [WIDTH-1:0] dev_val;
   assign bif.pad_i = (bif.pad_re_n === 1'b0) ? dev_val : ~dev_val;

   bidir_bus_port_ctrl #(
      .WIDTH(WIDTH), .TURN_CYCLES(TURN_CYCLES), .RD_WAIT(RD_WAIT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bif)
   );

   int tests = 0;
   int fails = 0;

   // Model: a transfer is a fixed-length timeline indexed from its accept edge
   bit               m_active = 1'b0;
   bit               m_is_rd  = 1'b0;
   int               m_k      = 0;
   int               m_total  = 0;
   logic [WIDTH-1:0] m_pad_o  = '0;
   logic [WIDTH-1:0] m_rd_data = '0;

   int n_drv, n_busy, n_we, n_re, n_rv;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic clr_counts();
      n_drv = 0; n_busy = 0; n_we = 0; n_re = 0; n_rv = 0;
   endtask

   task automatic tick();
      logic             r, w, rq;
      logic [WIDTH-1:0] wd, dv;
      logic             e_t, e_we, e_re, e_busy, e_v;
      r = reset; w = bif.wr_req; rq = bif.rd_req; wd = bif.wr_data; dv = dev_val;
      @(posedge clk);
      #1;
      if (r) begin
         m_active = 1'b0; m_pad_o = '0; m_rd_data = '0;
      end else if (m_active) begin
         m_k++;
         if (m_is_rd && m_k == int'(RD_WAIT)) m_rd_data = dv;
         if (m_k == m_total) m_active = 1'b0;
      end else if (w) begin
         m_active = 1'b1; m_is_rd = 1'b0; m_k = 0;
         m_total = 3 + int'(TURN_CYCLES); m_pad_o = wd;
      end else if (rq) begin
         m_active = 1'b1; m_is_rd = 1'b1; m_k = 0;
         m_total = int'(RD_WAIT + TURN_CYCLES);
      end
      e_t = 1'b1; e_we = 1'b1; e_re = 1'b1; e_v = 1'b0; e_busy = m_active;
      if (m_active && !m_is_rd) begin
         e_t  = (m_k < 3) ? 1'b0 : 1'b1;
         e_we = (m_k == 1) ? 1'b0 : 1'b1;
      end
      if (m_active && m_is_rd) begin
         e_re = (m_k < int'(RD_WAIT)) ? 1'b0 : 1'b1;
         e_v  = (m_k == int'(RD_WAIT));
      end
      chk("pad_t",    32'(bif.pad_t),    32'(e_t));
      chk("pad_we_n", 32'(bif.pad_we_n), 32'(e_we));
      chk("pad_re_n", 32'(bif.pad_re_n), 32'(e_re));
      chk("busy",     32'(bif.busy),     32'(e_busy));
      chk("rd_valid", 32'(bif.rd_valid), 32'(e_v));
      chk("pad_o",    32'(bif.pad_o),    32'(m_pad_o));
      chk("rd_data",  32'(bif.rd_data),  32'(m_rd_data));
      chk("contention", 32'(bif.pad_t === 1'b0 && bif.pad_re_n === 1'b0), 32'd0);
      n_drv  += (bif.pad_t === 1'b0)    ? 1 : 0;
      n_busy += (bif.busy === 1'b1)     ? 1 : 0;
      n_we   += (bif.pad_we_n === 1'b0) ? 1 : 0;
      n_re   += (bif.pad_re_n === 1'b0) ? 1 : 0;
      n_rv   += (bif.rd_valid === 1'b1) ? 1 : 0;
   endtask

   initial begin
      bit started;
      int gap;
      reset = 1'b1; bif.wr_req = 1'b1; bif.rd_req = 1'b0;
      bif.wr_data = 8'h77; dev_val = 8'h00;

      // Reset held with a pending write request
      clr_counts();
      repeat (2) tick();
      chk("reset_no_xfer", 32'(n_drv + n_busy), 32'd0);
      reset = 1'b0; bif.wr_req = 1'b0;
      tick();

      // Single write
      clr_counts();
      bif.wr_req = 1'b1; bif.wr_data = 8'hA5;
      tick();
      bif.wr_req = 1'b0; bif.wr_data = 8'h00;
      repeat (7) tick();
      chk("wr_drive_cycles", 32'(n_drv), 32'd3);
      chk("wr_strobe_cycles", 32'(n_we), 32'd1);
      chk("wr_busy_cycles", 32'(n_busy), 32'd5);
      chk("wr_pad_o", 32'(bif.pad_o), 32'h0A5);

      // Single read
      clr_counts();
      dev_val = 8'h3C; bif.rd_req = 1'b1;
      tick();
      bif.rd_req = 1'b0;
      repeat (6) tick();
      chk("rd_strobe_cycles", 32'(n_re), 32'd2);
      chk("rd_valid_pulses", 32'(n_rv), 32'd1);
      chk("rd_busy_cycles", 32'(n_busy), 32'd4);
      chk("rd_drive_cycles", 32'(n_drv), 32'd0);
      chk("rd_data_3c", 32'(bif.rd_data), 32'h03C);

      // Back-to-back: write, then a held read request
      bif.wr_req = 1'b1; bif.wr_data = 8'h11;
      tick();
      bif.wr_req = 1'b0; bif.rd_req = 1'b1; dev_val = 8'h5A;
      started = 1'b0; gap = 0;
      for (int i = 0; i < 20 && !started; i++) begin
         tick();
         if (bif.pad_re_n === 1'b0) started = 1'b1;
         else if (bif.pad_t === 1'b1) gap++;
      end
      chk("b2b_read_started", 32'(started), 32'd1);
      chk("b2b_released_gap", 32'(gap), 32'(TURN_CYCLES + 1));
      bif.rd_req = 1'b0;
      repeat (6) tick();
      chk("b2b_rd_data", 32'(bif.rd_data), 32'h05A);

      // Simultaneous requests: write wins, read dropped
      clr_counts();
      bif.wr_req = 1'b1; bif.rd_req = 1'b1; bif.wr_data = 8'hC3;
      tick();
      bif.wr_req = 1'b0; bif.rd_req = 1'b0;
      repeat (7) tick();
      chk("both_we_cycles", 32'(n_we), 32'd1);
      chk("both_re_cycles", 32'(n_re), 32'd0);
      chk("both_rd_valid", 32'(n_rv), 32'd0);
      chk("both_pad_o", 32'(bif.pad_o), 32'h0C3);

      // Reset during the write strobe, then a read of 0xFF
      bif.wr_req = 1'b1; bif.wr_data = 8'h99;
      tick();
      bif.wr_req = 1'b0;
      tick();
      chk("in_wstrobe", 32'(bif.pad_we_n), 32'd0);
      reset = 1'b1;
      tick();
      chk("abort_busy", 32'(bif.busy), 32'd0);
      reset = 1'b0; dev_val = 8'hFF; bif.rd_req = 1'b1;
      tick();
      bif.rd_req = 1'b0;
      repeat (6) tick();
      chk("after_abort_rd", 32'(bif.rd_data), 32'h0FF);

      // Random requests, data, device values and occasional resets
      for (int i = 0; i < 600; i++) begin
         reset       = ($urandom_range(0, 59) == 0);
         bif.wr_req  = ($urandom_range(0, 3) == 0);
         bif.rd_req  = ($urandom_range(0, 2) == 0);
         bif.wr_data = WIDTH'($urandom);
         dev_val     = WIDTH'($urandom);
         tick();
      end
      reset = 1'b0; bif.wr_req = 1'b0; bif.rd_req = 1'b0;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bidir_bus_port_ctrl.md
Name: bidir_bus_port_ctrl

Overview:
- Synchronous half-duplex controller for an external tri-state data bus built from per-bit bidirectional pad buffers.
- Produces the buffer drive value (pad_o) and active-high tristate control (pad_t: 1 = released, 0 = driving), and samples the buffer input path (pad_i).
- Generates active-low write/read strobes for the external device.
- Enforces guaranteed bus-turnaround cycles, so the FPGA never drives while the device may still be driving.
- Sits between an internal request interface (e.g. a processor port) and the pad ring.

Parameters:
WIDTH, 8, data bus width in bits
TURN_CYCLES, 2, released-bus cycles after every transfer; legal range 1..15
RD_WAIT, 2, cycles pad_re_n is held low per read; legal range 1..15

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_req  input  1  write request; sampled only when busy=0
wr_data  input  WIDTH  write data; captured in the accept cycle
rd_req  input  1  read request; sampled only when busy=0
rd_data  output  WIDTH  last read value; holds until the next read completes
rd_valid  output  1  one-cycle pulse: rd_data was updated
busy  output  1  transfer in progress; requests ignored while high
pad_o  output  WIDTH  value the pad buffers drive onto the bus
pad_t  output  1  tristate control; 1 = bus released, 0 = FPGA drives
pad_i  input  WIDTH  value read back from the pad buffers
pad_we_n  output  1  active-low write strobe to the device
pad_re_n  output  1  active-low read strobe to the device

Behaviour:
- All outputs are registered. Reset is synchronous, active-high.
- Reset values: state IDLE, pad_t=1, pad_o=0, pad_we_n=1, pad_re_n=1, busy=0, rd_valid=0, rd_data=0.
- States: IDLE, WSETUP, WSTROBE, WHOLD, RSTROBE, TURN.
- IDLE:
  - Accept occurs when busy=0 and wr_req or rd_req is high.
  - If both requests are high, the write wins and the read is dropped; the requester must re-assert it.
  - Write accept: latch wr_data and go to WSETUP. Read accept: go to RSTROBE.
  - busy rises on the clock edge that leaves IDLE.
- WSETUP (1 cycle): pad_t=0, pad_o=latched data, pad_we_n=1.
- WSTROBE (1 cycle): pad_t=0, pad_we_n=0, data unchanged.
- WHOLD (1 cycle): pad_t=0, pad_we_n=1, data unchanged. Then go to TURN.
- Data stability: pad_o is stable from WSETUP through WHOLD, giving one full cycle of setup and one of hold around the strobe.
- RSTROBE (RD_WAIT cycles, 4-bit down-counter):
  - pad_t=1 and pad_re_n=0 throughout.
  - On the final RSTROBE cycle edge, rd_data <= pad_i; then go to TURN.
- TURN (TURN_CYCLES cycles, counter):
  - pad_t=1, both strobes high.
  - rd_valid=1 during the first TURN cycle after a read only; 0 at all other times.
  - Leaving TURN returns to IDLE with busy=0.
- Latency from accept edge until busy falls: write = 3+TURN_CYCLES cycles; read = RD_WAIT+TURN_CYCLES cycles.
  - Default write: 5 busy cycles. Default read: 4 busy cycles.
- Invariants:
  - pad_t=0 never coincides with pad_re_n=0.
  - pad_t changes from 1 to 0 only on entry to WSETUP, which is always preceded by IDLE, so at least TURN_CYCLES released cycles separate any two transfers.
- Requests asserted while busy=1 are ignored, not queued. A request held high is accepted in the first IDLE cycle.
- pad_o keeps its last written value while released. It is don't-care electrically but stays deterministic.
- Reset mid-transfer: the next edge forces all reset values. A partial write or read is abandoned with no rd_valid.
- Counters reload on every state entry. No wrap-around is possible within the legal parameter ranges.

Test Plan:
- Reset: reset=1 for 2 cycles with wr_req=1 -> pad_t=1, both strobes 1, busy=0, rd_data=0, no transfer starts while reset is high.
- Single write: wr_data=0xA5 pulse -> pad_t=0 for exactly 3 cycles; pad_o=0xA5 in all three; pad_we_n low only in the middle cycle; busy high for 5 cycles.
- Single read: device model drives 0x3C while pad_re_n=0 -> pad_re_n low 2 cycles; rd_valid pulse 1 cycle with rd_data=0x3C; pad_t stays 1 throughout; busy high for 4 cycles.
- Back-to-back: write 0x11 then read, with rd_req held high -> read accepted only after 2 released TURN cycles; a bus-contention checker (pad_t=0 while the device drives) never fires.
- Simultaneous wr_req=rd_req=1 in IDLE -> write of wr_data executed, no read strobe, no rd_valid.
- Reset in WSTROBE -> next cycle pad_t=1, pad_we_n=1, busy=0, state IDLE; a subsequent read with device value 0xFF returns rd_data=0xFF.
